// File: rtl/iiitb_usr_rx.sv
`default_nettype none
// ============================================================================
// Module      : iiitb_usr_rx
// Description : Receive end of the universal-shift-register serial link.
//               Deserialises one WIDTH-bit frame at a time, arriving either
//               LSB first (dir=1, right shift) or MSB first (dir=0, left
//               shift). The frame is rebuilt in a shift register and handed
//               to the consumer through a valid/ready output register. A
//               completed word that cannot be handed over because the
//               previous word is still unconsumed is dropped, and the sticky
//               overrun flag is set.
// Optional    : IIITB_USR_RX_PARITY_EN - when defined, each frame carries one
//               extra even-parity bit after the data bits and par_err reports
//               a parity mismatch on the current dout. When undefined,
//               par_err is tied to 0. The port list is the same in both builds.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous reset, active low
//               clr        - synchronous flush, active high
//               dir        - frame direction, sampled with the first bit
//               sin        - serial data bit
//               sin_valid  - sin is sampled on this edge when high
//               dout       - received word
//               dout_valid - dout holds an unconsumed word
//               dout_ready - consumer accepts dout
//               busy       - frame in progress
//               overrun    - sticky: a completed word was dropped
//               par_err    - parity mismatch on the current dout
// Revision    : 1.0 - initial release
// ============================================================================
module iiitb_usr_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             dir,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);

    localparam int                c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
`ifdef IIITB_USR_RX_PARITY_EN
        ,
        ST_PAR   = 2'd3
`endif
    } t_state;

    t_state             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sr;
    logic               r_dir_q;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_overrun;
    logic [c_cnt_w-1:0] w_cnt_inc;
`ifdef IIITB_USR_RX_PARITY_EN
    logic               r_par_bit;
    logic               r_par_err;
`endif

    // Right shift pushes the new bit in at the MSB, left shift at the LSB, so
    // a word arrives in its transmitted bit order in either direction.
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] sr,
                                                 input logic             d,
                                                 input logic             b);
        return d ? {b, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], b};
    endfunction

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_dir_q      <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef IIITB_USR_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_par_err    <= 1'b0;
`endif
        end else if (clr) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_dir_q      <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef IIITB_USR_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_par_err    <= 1'b0;
`endif
        end else begin
            // Consumer handshake; a reload in ST_LOAD below overrides this so
            // valid stays high when a new word lands on the same edge.
            if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
`ifdef IIITB_USR_RX_PARITY_EN
                r_par_err    <= 1'b0;
`endif
            end

            case (r_state)
                ST_IDLE: begin
                    if (sin_valid) begin
                        // First bit uses the live dir; later bits use dir_q.
                        r_dir_q <= dir;
                        r_sr    <= f_shift(r_sr, dir, sin);
                        r_cnt   <= c_cnt_w'(1);
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (sin_valid) begin
                        r_sr  <= f_shift(r_sr, r_dir_q, sin);
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_last) begin
`ifdef IIITB_USR_RX_PARITY_EN
                            r_state <= ST_PAR;
`else
                            r_state <= ST_LOAD;
`endif
                        end
                    end
                end

`ifdef IIITB_USR_RX_PARITY_EN
                ST_PAR: begin
                    if (sin_valid) begin
                        r_par_bit <= sin;
                        r_state   <= ST_LOAD;
                    end
                end
`endif

                ST_LOAD: begin
                    if (!r_dout_valid || dout_ready) begin
                        r_dout       <= r_sr;
                        r_dout_valid <= 1'b1;
`ifdef IIITB_USR_RX_PARITY_EN
                        // Even parity: the bit should equal the XOR of the data.
                        r_par_err    <= (r_par_bit != ^r_sr);
`endif
                    end else begin
                        r_overrun <= 1'b1;
                    end
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);
`ifdef IIITB_USR_RX_PARITY_EN
    assign par_err    = r_par_err;
`else
    assign par_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iiitb_usr_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_iiitb_usr_rx
// Description : Self-checking bench for iiitb_usr_rx. Directed frames and a
//               randomized stream are checked cycle by cycle against a
//               frame-level reference model (bit list -> word, plus a
//               single-entry output slot with overrun accounting).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iiitb_usr_rx;

    localparam int WIDTH = 4;
`ifdef IIITB_USR_RX_PARITY_EN
    localparam int c_frame = WIDTH + 1;
`else
    localparam int c_frame = WIDTH;
`endif

    logic             clk;
    logic             reset;
    logic             clr;
    logic             dir;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;
    logic             par_err;

    int n_cmp;
    int n_err;

    // Reference model state
    int               m_nbits;
    logic [WIDTH-1:0] m_acc;
    logic             m_dir;
    logic             m_pending;
    logic [WIDTH-1:0] m_pword;
    logic             m_pperr;
    logic [WIDTH-1:0] m_dout;
    logic             m_dv;
    logic             m_ovr;
    logic             m_perr;

    iiitb_usr_rx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .dir        (dir),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .par_err    (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_zero();
        m_nbits   = 0;
        m_acc     = '0;
        m_dir     = 1'b0;
        m_pending = 1'b0;
        m_pword   = '0;
        m_pperr   = 1'b0;
        m_dout    = '0;
        m_dv      = 1'b0;
        m_ovr     = 1'b0;
        m_perr    = 1'b0;
    endtask

    // One rising edge of the reference model, using the inputs as driven.
    task automatic model_edge();
        if (!reset || clr) begin
            model_zero();
        end else if (m_pending) begin
            // Word hand-over cycle; serial input is ignored here.
            if (!m_dv || dout_ready) begin
                m_dout = m_pword;
                m_dv   = 1'b1;
                m_perr = m_pperr;
            end else begin
                m_ovr = 1'b1;
            end
            m_pending = 1'b0;
        end else begin
            if (m_dv && dout_ready) begin
                m_dv   = 1'b0;
                m_perr = 1'b0;
            end
            if (sin_valid) begin
                if (m_nbits == 0) begin
                    m_dir = dir;
                    m_acc = '0;
                end
                if (m_nbits < WIDTH) begin
                    // Bit number n of the frame is word bit n (LSB first) or
                    // word bit WIDTH-1-n (MSB first).
                    if (m_dir) m_acc[m_nbits] = sin;
                    else       m_acc[WIDTH-1-m_nbits] = sin;
                    m_pperr = 1'b0;
                end else begin
                    m_pperr = (sin != ^m_acc);
                end
                m_nbits++;
                if (m_nbits == c_frame) begin
                    m_pword   = m_acc;
                    m_pending = 1'b1;
                    m_nbits   = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic m_busy;
        m_busy = (m_nbits != 0) || m_pending;
        chk({tag, ".dout"},       32'(dout),       32'(m_dout));
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_dv));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
        chk({tag, ".par_err"},    32'(par_err),    32'(m_perr));
        chk({tag, ".busy"},       32'(busy),       32'(m_busy));
    endtask

    task automatic step(input string tag, input logic sv, input logic s,
                        input logic d, input logic rdy, input logic c);
        sin_valid  = sv;
        sin        = s;
        dir        = d;
        dout_ready = rdy;
        clr        = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Sends one frame of the given word, optional idle gap before the last
    // data bit, then one idle cycle for the hand-over.
    task automatic send(input string tag, input logic [WIDTH-1:0] w, input logic d,
                        input logic rdy, input int gap, input logic pbit);
        logic b;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                for (int g = 0; g < gap; g++) step({tag, ".gap"}, 1'b0, 1'b1, ~d, rdy, 1'b0);
            end
            b = d ? w[i] : w[WIDTH-1-i];
            step({tag, ".bit"}, 1'b1, b, d, rdy, 1'b0);
        end
`ifdef IIITB_USR_RX_PARITY_EN
        step({tag, ".par"}, 1'b1, pbit, d, rdy, 1'b0);
`else
        if (pbit) begin
            // No parity bit in this build; the argument is ignored.
        end
`endif
        step({tag, ".load"}, 1'b0, 1'b0, d, rdy, 1'b0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        clr        = 1'b0;
        dir        = 1'b1;
        sin        = 1'b1;
        sin_valid  = 1'b1;
        dout_ready = 1'b1;
        model_zero();

        // Reset held for three cycles with sin_valid high
        for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;

        // Right shift with a two-cycle gap before the last bit
        step("first_bit", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("first_bit.busy_lit", 32'(busy), 32'd1);
        step("rs.b1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rs.b2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rs.gap", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("rs.gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rs.b3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("rs.load", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rs.dout_lit", 32'(dout), 32'h9);
        chk("rs.dv_lit", 32'(dout_valid), 32'd1);
        step("rs.drain", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rs.dv_one_cycle", 32'(dout_valid), 32'd0);

        // Left shift frames
        send("ls1", 4'b1001, 1'b0, 1'b1, 0, 1'b0);
        chk("ls1.dout_lit", 32'(dout), 32'h9);
        send("ls2", 4'b1100, 1'b0, 1'b1, 0, 1'b0);
        chk("ls2.dout_lit", 32'(dout), 32'hC);
        step("ls.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure and overrun
        send("bp1", 4'b1001, 1'b1, 1'b0, 0, 1'b0);
        step("bp.idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send("bp2", 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp.dout_lit", 32'(dout), 32'h9);
        chk("bp.ovr_lit", 32'(overrun), 32'd1);
        step("bp.accept", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("bp.dv_lit", 32'(dout_valid), 32'd0);
        step("bp.clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("bp.ovr_clr_lit", 32'(overrun), 32'd0);

        // Reset in the middle of a frame
        step("mr.b0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("mr.b1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        model_zero();
        check_all("mr.async");
        step("mr.hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        send("mr.frame", 4'b0101, 1'b1, 1'b1, 0, 1'b0);
        chk("mr.dout_lit", 32'(dout), 32'h5);

`ifdef IIITB_USR_RX_PARITY_EN
        step("par.idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send("par.good", 4'b1001, 1'b1, 1'b1, 0, 1'b0);
        chk("par.good_lit", 32'(par_err), 32'd0);
        step("par.idle2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send("par.bad", 4'b1001, 1'b1, 1'b1, 0, 1'b1);
        chk("par.bad_lit", 32'(par_err), 32'd1);
        chk("par.bad_dout", 32'(dout), 32'h9);
`endif

        // Randomized stream against the model
        for (int i = 0; i < 800; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 59) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
